// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle control path: opcodes, ALU codes,
// ALU B-select codes and the 4-bit sequencer state encoding.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_RS2  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;
  localparam logic [1:0] ALUB_BOFF = 2'b11;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // Dispatch target out of DECODE; anything unsupported lands in the trap.
  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_R:              return S_EXEC_R;
      OP_I:              return S_EXEC_I;
      OP_LOAD, OP_STORE: return S_MEM_ADDR;
      OP_BRANCH:         return S_BRANCH;
      default:           return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; flags the cycle in which the
// MEM_TIMEOUT-th consecutive not-ready cycle occurs (MEM_TIMEOUT = 0 disables).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(MEM_TIMEOUT - 32'd1);

  logic [TMO_W-1:0] cnt_r;

  // Wait-cycle counter: cleared on state entry, advanced per not-ready cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout = (MEM_TIMEOUT != 32'd0) && en && (cnt_r == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer (R, ADDI-class, LW, SW, BEQ) driving the
// shared ALU, register file and unified memory port, with a memory-wait timeout.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic       pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state
);

  state_t state_r, state_next_s;
  logic   is_store_r, illegal_op_r, bus_err_r;
  logic   waiting_s, timeout_s, pc_write_s, pc_write_cond_s;

  assign waiting_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(TMO_W)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_next_s != state_r),
    .en      (waiting_s && !mem_ready),
    .timeout (timeout_s)
  );

  // State, load/store memory across MEM_ADDR, and the two sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_RESET;
      is_store_r   <= 1'b0;
      illegal_op_r <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      is_store_r   <= (state_r == S_DECODE) ? (opcode == OP_STORE) : is_store_r;
      illegal_op_r <= illegal_op_r | ((state_r == S_DECODE) && (decode_next(opcode) == S_TRAP));
      bus_err_r    <= bus_err_r | timeout_s;
    end
  end

  // Next-state: wait states exit on ready, trap on timeout, otherwise hold.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_RESET:    state_next_s = S_FETCH;
      S_FETCH:    if (mem_ready) state_next_s = S_DECODE;
                  else if (timeout_s) state_next_s = S_TRAP;
                  else state_next_s = state_r;
      S_DECODE:   state_next_s = decode_next(opcode);
      S_EXEC_R:   state_next_s = S_ALU_WB;
      S_EXEC_I:   state_next_s = S_ALU_WB;
      S_ALU_WB:   state_next_s = S_FETCH;
      S_MEM_ADDR: state_next_s = is_store_r ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_next_s = S_MEM_WB;
                  else if (timeout_s) state_next_s = S_TRAP;
                  else state_next_s = state_r;
      S_MEM_WB:   state_next_s = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_next_s = S_FETCH;
                  else if (timeout_s) state_next_s = S_TRAP;
                  else state_next_s = state_r;
      S_BRANCH:   state_next_s = S_FETCH;
      S_TRAP:     state_next_s = S_TRAP;
      default:    state_next_s = S_TRAP;
    endcase
  end

  // Datapath controls decoded from the state register; ir_write/pc_en also follow mem_ready.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    iord            = 1'b0;
    ir_write        = 1'b0;
    pc_source       = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = ALUB_RS2;
    alu_op          = ALUOP_ADD;
    mem_to_reg      = 1'b0;
    reg_write       = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write_s = 1'b1;
        end else begin
          ir_write   = 1'b0;
          pc_write_s = 1'b0;
        end
      end
      S_DECODE:   alu_src_b = ALUB_BOFF;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB:   reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = ALUOP_SUB;
        pc_source       = 1'b1;
        pc_write_cond_s = 1'b1;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
    pc_en = pc_write_s | (pc_write_cond_s & zero);
  end

  assign illegal_op = illegal_op_r;
  assign bus_err    = bus_err_r;
  assign state      = state_r;

endmodule
